// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU run monitor: FSM states, trace entry
// layout and the core's opcode encoding (opcode lives in instr[15:12]).
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2,
        ST_TMO  = 2'd3
    } state_t;

    localparam int INSTR_W     = 16;
    localparam int TRACE_CYC_W = 16;
    localparam int TRACE_PC_W  = 16;

    // Entry layout at default widths; the top builds the same field order at its own widths.
    typedef struct packed {
        logic [TRACE_CYC_W-1:0] cycle;
        logic [TRACE_PC_W-1:0]  pc;
        logic [INSTR_W-1:0]     instr;
        logic                   zero;
    } trace_entry_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:INSTR_W-4];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with occupancy count, sticky overflow and a selectable
// full policy (drop the new entry, or overwrite the oldest one).
module trace_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int OVERWRITE = 0,
    localparam int AW       = $clog2(DEPTH),
    localparam int CNT_W    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_write;
    logic             drop_old;
    logic             lost;

    assign valid    = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && valid;
    // A pop on a full FIFO frees the slot the push needs, so only a pop-less push can be lost.
    assign lost     = push && full && !do_pop;
    assign drop_old = lost && (OVERWRITE != 0);
    assign do_write = push && (!lost || drop_old);
    assign rdata    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop || drop_old)
                rd_ptr <= rd_ptr + 1'b1;
            if (lost)
                overflow <= 1'b1;
            if (do_write && !do_pop && !drop_old)
                count <= count + 1'b1;
            else if (do_pop && !do_write)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !clr)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cpu_trace_unit.sv
// Run monitor beside the 16-bit core: shadows register writebacks, logs
// commits to a trace FIFO and ends the run on STOP_PC or a cycle timeout.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   ST_RUN  | program running; commits logged, cycles counted
//   ST_PASS | stop PC reached and checked register matched
//   ST_FAIL | stop PC reached and checked register differed
//   ST_TMO  | cycle budget exhausted before the stop PC
module cpu_trace_unit
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int PC_W      = 16,
    parameter int NREGS     = 8,
    parameter int DEPTH     = 16,
    parameter int CYC_W     = 16,
    parameter int OVERWRITE = 0,
    parameter int STOP_PC   = 32,
    parameter int TIMEOUT   = 100,
    parameter int CHECK_REG = 6,
    parameter int CHECK_VAL = 0,
    localparam int RA_W     = $clog2(NREGS),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              commit_valid,
    input  logic [PC_W-1:0]   commit_pc,
    input  logic [15:0]       commit_instr,
    input  logic              commit_zero,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              trace_rd_en,
    output logic              trace_valid,
    output logic [CYC_W-1:0]  trace_cycle,
    output logic [PC_W-1:0]   trace_pc,
    output logic [15:0]       trace_instr,
    output logic              trace_zero,
    output logic [CNT_W-1:0]  trace_count,
    output logic              overflow,
    output logic              done,
    output logic              halted,
    output logic              pass,
    output logic              timeout
);

    typedef struct packed {
        logic [CYC_W-1:0] cycle;
        logic [PC_W-1:0]  pc;
        logic [15:0]      instr;
        logic             zero;
    } entry_t;

    localparam logic [PC_W-1:0]   STOP_PC_V = PC_W'(STOP_PC);
    localparam logic [CYC_W-1:0]  TMO_LAST  = CYC_W'(TIMEOUT - 1);
    localparam logic [RA_W-1:0]   CHK_IDX   = RA_W'(CHECK_REG);
    localparam logic [DATA_W-1:0] CHK_VAL   = DATA_W'(CHECK_VAL);

    state_t            state;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [DATA_W-1:0] shadow [NREGS];
    logic              in_run;
    logic              log_en;
    logic              stop_hit;
    logic              tmo_hit;
    logic [DATA_W-1:0] cmp_val;
    entry_t            push_entry;
    entry_t            head;

    assign in_run   = (state == ST_RUN);
    assign log_en   = commit_valid && in_run;
    assign stop_hit = log_en && (commit_pc == STOP_PC_V);
    assign tmo_hit  = in_run && (cyc_cnt == TMO_LAST);
    // The stop commit's own writeback is not in the shadow yet, so bypass it.
    assign cmp_val  = (wb_en && (wb_addr == CHK_IDX)) ? wb_data : shadow[CHK_IDX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cyc_cnt <= '0;
            done    <= 1'b0;
            halted  <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else if (restart) begin
            state   <= ST_RUN;
            cyc_cnt <= '0;
            done    <= 1'b0;
            halted  <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_run) begin
                if (cyc_cnt != '1)
                    cyc_cnt <= cyc_cnt + 1'b1;
                if (stop_hit) begin
                    done   <= 1'b1;
                    halted <= 1'b1;
                    if (cmp_val == CHK_VAL) begin
                        state <= ST_PASS;
                        pass  <= 1'b1;
                    end else begin
                        state <= ST_FAIL;
                    end
                end else if (tmo_hit) begin
                    state   <= ST_TMO;
                    done    <= 1'b1;
                    halted  <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '{default: '0};
        end else if (restart) begin
            shadow <= '{default: '0};
        end else if (log_en && wb_en) begin
            shadow[wb_addr] <= wb_data;
        end
    end

    assign push_entry = '{cycle: cyc_cnt, pc: commit_pc, instr: commit_instr, zero: commit_zero};

    trace_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    ($bits(entry_t)),
        .OVERWRITE(OVERWRITE)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (restart),
        .push    (log_en),
        .pop     (trace_rd_en),
        .wdata   (push_entry),
        .rdata   (head),
        .valid   (trace_valid),
        .count   (trace_count),
        .overflow(overflow)
    );

    assign trace_cycle = head.cycle;
    assign trace_pc    = head.pc;
    assign trace_instr = head.instr;
    assign trace_zero  = head.zero;

endmodule
